// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the APB master controller.
// Address map, slave selects and FSM state encoding.
package apb_ctrl_pkg;

  localparam int PSEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam logic [31:0] S0_BASE  = 32'h8000_0000;
  localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] S1_BASE  = 32'h8400_0000;
  localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] S2_BASE  = 32'h8800_0000;
  localparam logic [31:0] S2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [PSEL_W-1:0] PSEL_NONE = 3'b000;
  localparam logic [PSEL_W-1:0] PSEL_S0   = 3'b001;
  localparam logic [PSEL_W-1:0] PSEL_S1   = 3'b010;
  localparam logic [PSEL_W-1:0] PSEL_S2   = 3'b100;

  function automatic logic in_range(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake plus APB bus signals.
// master = controller view, slave = requester/APB-side view.
interface apb_master_ctrl_if;
  import apb_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              pwrite;
  logic              penable;
  logic [PSEL_W-1:0] psel;
  logic [31:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  prdata, pready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output pwrite, penable, psel, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output prdata, pready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  pwrite, penable, psel, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_ctrl_addr_decode.sv
// Combinational address decoder: address to one-hot select.
// Anything outside the three windows is reported as a miss.
module apb_addr_decode
  import apb_ctrl_pkg::*;
(
  input  logic [31:0]       addr,
  output logic              hit,
  output logic [PSEL_W-1:0] psel
);

  logic in_s0;
  logic in_s1;
  logic in_s2;

  assign in_s0 = in_range(addr, S0_BASE, S0_LIMIT);
  assign in_s1 = in_range(addr, S1_BASE, S1_LIMIT);
  assign in_s2 = in_range(addr, S2_BASE, S2_LIMIT);

  // windows are disjoint, so at most one match
  always_comb begin
    hit  = 1'b0;
    psel = PSEL_NONE;
    unique case (1'b1)
      in_s0: begin hit = 1'b1; psel = PSEL_S0; end
      in_s1: begin hit = 1'b1; psel = PSEL_S1; end
      in_s2: begin hit = 1'b1; psel = PSEL_S2; end
      default: ;
    endcase
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB side sequencer of the AHB2APB bridge.
// One request at a time: SETUP, ACCESS with timeout, one-cycle RESP.
module apb_master_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              hclk,
  input  logic              hreset,
  apb_master_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [PSEL_W-1:0] psel_q, psel_n;
  logic              pen_q, pen_n;
  logic              pwr_q, pwr_n;
  logic [31:0]       paddr_q, paddr_n;
  logic [31:0]       pwdata_q, pwdata_n;
  logic              rv_q, rv_n;
  logic [31:0]       rdata_q, rdata_n;
  logic              err_q, err_n;

  logic              dec_hit;
  logic [PSEL_W-1:0] dec_psel;

  apb_addr_decode u_dec (
    .addr (bus.req_addr),
    .hit  (dec_hit),
    .psel (dec_psel)
  );

  // next state and next registered outputs
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    psel_n   = psel_q;
    pen_n    = pen_q;
    pwr_n    = pwr_q;
    paddr_n  = paddr_q;
    pwdata_n = pwdata_q;
    rv_n     = 1'b0;
    rdata_n  = rdata_q;
    err_n    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (dec_hit) begin
            state_n  = SETUP;
            psel_n   = dec_psel;
            pen_n    = 1'b0;
            pwr_n    = bus.req_write;
            paddr_n  = bus.req_addr;
            pwdata_n = bus.req_wdata;
          end else begin
            state_n = RESP;
            rv_n    = 1'b1;
            err_n   = 1'b1;
            rdata_n = '0;
          end
        end
      end
      SETUP: begin
        state_n = ACCESS;
        pen_n   = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          state_n = RESP;
          psel_n  = PSEL_NONE;
          pen_n   = 1'b0;
          rv_n    = 1'b1;
          err_n   = 1'b0;
          rdata_n = pwr_q ? '0 : bus.prdata;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_n = RESP;
          psel_n  = PSEL_NONE;
          pen_n   = 1'b0;
          rv_n    = 1'b1;
          err_n   = 1'b1;
          rdata_n = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      psel_q   <= PSEL_NONE;
      pen_q    <= 1'b0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      psel_q   <= psel_n;
      pen_q    <= pen_n;
      pwr_q    <= pwr_n;
      paddr_q  <= paddr_n;
      pwdata_q <= pwdata_n;
      rv_q     <= rv_n;
      rdata_q  <= rdata_n;
      err_q    <= err_n;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = pen_q;
  assign bus.pwrite    = pwr_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_apb_master_ctrl;

  logic hclk;
  logic hreset;
  int   nvec;
  int   nerr;
  int   npen;

  apb_master_ctrl_if bus ();

  apb_master_ctrl #(
    .TIMEOUT (16),
    .CNT_W   (5)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus.master)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    hreset        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    tick();
    tick();
    hreset = 1'b0;

    chk("rst_psel", 32'(bus.psel), 32'h0);
    chk("rst_pen", 32'(bus.penable), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_rv", 32'(bus.rsp_valid), 32'h0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_err", 32'(bus.rsp_err), 32'h0);

    // zero-wait write
    bus.pready = 1'b1;
    req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = 1'b0;
    chk("w_setup_psel", 32'(bus.psel), 32'h1);
    chk("w_setup_pen", 32'(bus.penable), 32'h0);
    chk("w_setup_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("w_acc_pen", 32'(bus.penable), 32'h1);
    chk("w_acc_psel", 32'(bus.psel), 32'h1);
    chk("w_acc_paddr", bus.paddr, 32'h8000_0010);
    chk("w_acc_pwdata", bus.pwdata, 32'hDEAD_BEEF);
    chk("w_acc_pwrite", 32'(bus.pwrite), 32'h1);
    tick();
    chk("w_rsp_rv", 32'(bus.rsp_valid), 32'h1);
    chk("w_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("w_rsp_psel", 32'(bus.psel), 32'h0);
    chk("w_rsp_pen", 32'(bus.penable), 32'h0);
    tick();
    chk("w_idle_rv", 32'(bus.rsp_valid), 32'h0);
    chk("w_idle_ready", 32'(bus.req_ready), 32'h1);

    // read with three wait states
    bus.pready = 1'b0;
    req(1'b0, 32'h8400_0004, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("r_setup_psel", 32'(bus.psel), 32'h2);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("r_wait_pen", 32'(bus.penable), 32'h1);
      chk("r_wait_rv", 32'(bus.rsp_valid), 32'h0);
      tick();
    end
    chk("r_last_pen", 32'(bus.penable), 32'h1);
    chk("r_last_psel", 32'(bus.psel), 32'h2);
    chk("r_last_pwrite", 32'(bus.pwrite), 32'h0);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0042;
    tick();
    bus.pready = 1'b0;
    bus.prdata = '0;
    chk("r_rsp_rv", 32'(bus.rsp_valid), 32'h1);
    chk("r_rsp_rdata", bus.rsp_rdata, 32'h0000_0042);
    chk("r_rsp_err", 32'(bus.rsp_err), 32'h0);
    tick();
    chk("r_hold_rdata", bus.rsp_rdata, 32'h0000_0042);
    chk("r_hold_rv", 32'(bus.rsp_valid), 32'h0);

    // decode miss
    req(1'b0, 32'h9000_0000, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("m_rv", 32'(bus.rsp_valid), 32'h1);
    chk("m_err", 32'(bus.rsp_err), 32'h1);
    chk("m_rdata", bus.rsp_rdata, 32'h0);
    chk("m_psel", 32'(bus.psel), 32'h0);
    chk("m_paddr_hold", bus.paddr, 32'h8400_0004);
    tick();
    chk("m_idle_psel", 32'(bus.psel), 32'h0);
    chk("m_idle_rv", 32'(bus.rsp_valid), 32'h0);

    // timeout; pready high during SETUP must be ignored
    req(1'b0, 32'h8800_0000, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("t_setup_psel", 32'(bus.psel), 32'h4);
    bus.pready = 1'b1;
    bus.prdata = 32'h1234_5678;
    tick();
    bus.pready = 1'b0;
    chk("t_acc_pen", 32'(bus.penable), 32'h1);
    chk("t_acc_rv", 32'(bus.rsp_valid), 32'h0);
    npen = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.rsp_valid) break;
      if (bus.penable) npen++;
    end
    bus.prdata = '0;
    chk("t_pen_cycles", 32'(npen), 32'd16);
    chk("t_rv", 32'(bus.rsp_valid), 32'h1);
    chk("t_err", 32'(bus.rsp_err), 32'h1);
    chk("t_rdata", bus.rsp_rdata, 32'h0);
    chk("t_psel", 32'(bus.psel), 32'h0);
    tick();
    chk("t_idle_ready", 32'(bus.req_ready), 32'h1);

    // back-to-back with req_valid held
    bus.pready = 1'b1;
    req(1'b1, 32'h8000_0000, 32'h0000_0001);
    tick();
    req(1'b1, 32'h8400_0000, 32'h0000_0002);
    chk("b1_psel", 32'(bus.psel), 32'h1);
    chk("b1_paddr_s", bus.paddr, 32'h8000_0000);
    tick();
    chk("b1_paddr_a", bus.paddr, 32'h8000_0000);
    chk("b1_pwdata", bus.pwdata, 32'h0000_0001);
    tick();
    chk("b1_rv", 32'(bus.rsp_valid), 32'h1);
    tick();
    chk("b2_ready", 32'(bus.req_ready), 32'h1);
    chk("b2_psel_idle", 32'(bus.psel), 32'h0);
    tick();
    bus.req_valid = 1'b0;
    chk("b2_psel", 32'(bus.psel), 32'h2);
    chk("b2_paddr_s", bus.paddr, 32'h8400_0000);
    tick();
    chk("b2_paddr_a", bus.paddr, 32'h8400_0000);
    chk("b2_pwdata", bus.pwdata, 32'h0000_0002);
    tick();
    chk("b2_rv", 32'(bus.rsp_valid), 32'h1);
    chk("b2_err", 32'(bus.rsp_err), 32'h0);
    tick();

    // reset in the middle of ACCESS
    bus.pready = 1'b0;
    req(1'b0, 32'h8000_0000, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("x_acc_pen", 32'(bus.penable), 32'h1);
    hreset = 1'b1;
    tick();
    chk("x_psel", 32'(bus.psel), 32'h0);
    chk("x_pen", 32'(bus.penable), 32'h0);
    chk("x_ready", 32'(bus.req_ready), 32'h1);
    chk("x_rv", 32'(bus.rsp_valid), 32'h0);
    tick();
    hreset = 1'b0;
    tick();
    chk("x_post_rv", 32'(bus.rsp_valid), 32'h0);
    chk("x_post_ready", 32'(bus.req_ready), 32'h1);
    chk("x_post_paddr", bus.paddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
